// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: request payload bundle,
// transaction owner and sequencer state.
package dmem_arbiter_pkg;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  byte_en;
    logic        wen;
  } dmem_req_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_D    = 2'd2
  } dmem_owner_e;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } dmem_arb_state_e;

endpackage

// File: rtl/dmem_arbiter_select.sv
// Requester selection: fixed priority to P, D forced once it has been passed
// over STARVE_LIMIT times; a held (locked) selection overrides both.
module dmem_arb_select
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             p_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  input  logic             lock_valid,
  input  dmem_owner_e      lock_sel,
  output dmem_owner_e      sel
);

  logic d_starved;

  assign d_starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    sel = OWN_P;
    if (lock_valid) begin
      sel = lock_sel;
    end else if (d_req && (!p_req || d_starved)) begin
      sel = OWN_D;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single data-memory port: one
// transaction outstanding, zero-bubble reissue on the response cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_req,
  input  logic [63:0] p_addr,
  input  logic [63:0] p_wdata,
  input  logic [7:0]  p_byte_en,
  input  logic        p_wen,
  output logic        p_gnt,
  output logic        p_rvalid,
  output logic [63:0] p_rdata,
  input  logic        d_req,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_byte_en,
  input  logic        d_wen,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        m_req,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  output logic [7:0]  m_byte_en,
  output logic        m_wen,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [63:0] m_rdata,
  output logic        unexpected_rsp
);

  dmem_arb_state_e  state_reg, state_next;
  dmem_owner_e      owner_reg, owner_next;
  logic             lock_valid_reg, lock_valid_next;
  dmem_owner_e      lock_sel_reg, lock_sel_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  dmem_owner_e sel;
  logic        sel_d;
  logic        issue_win;
  logic        accept;
  logic        rsp_live;
  dmem_req_t   p_bus, d_bus, m_bus;

  dmem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_select (
    .p_req     (p_req),
    .d_req     (d_req),
    .starve_cnt(cnt_reg),
    .lock_valid(lock_valid_reg),
    .lock_sel  (lock_sel_reg),
    .sel       (sel)
  );

  assign sel_d = (sel == OWN_D);
  assign p_bus = '{addr: p_addr, wdata: p_wdata, byte_en: p_byte_en, wen: p_wen};
  assign d_bus = '{addr: d_addr, wdata: d_wdata, byte_en: d_byte_en, wen: d_wen};
  assign m_bus = sel_d ? d_bus : p_bus;

  // A new request may go out while idle, or alongside the response that
  // retires the outstanding one.
  assign issue_win = (state_reg == IDLE) || m_rvalid;
  assign m_req     = rst_n && issue_win && (p_req || d_req);
  assign m_addr    = m_bus.addr;
  assign m_wdata   = m_bus.wdata;
  assign m_byte_en = m_bus.byte_en;
  assign m_wen     = m_req && m_bus.wen;

  assign accept = m_req && m_gnt;
  assign p_gnt  = accept && !sel_d;
  assign d_gnt  = accept && sel_d;

  assign rsp_live       = m_rvalid && (state_reg == WAIT_RSP);
  assign p_rvalid       = rsp_live && (owner_reg == OWN_P);
  assign d_rvalid       = rsp_live && (owner_reg == OWN_D);
  assign p_rdata        = m_rdata;
  assign d_rdata        = m_rdata;
  assign unexpected_rsp = rst_n && m_rvalid && (state_reg == IDLE);

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    lock_valid_next = lock_valid_reg;
    lock_sel_next   = lock_sel_reg;
    cnt_next        = cnt_reg;

    if (accept) begin
      state_next      = WAIT_RSP;
      owner_next      = sel;
      lock_valid_next = 1'b0;
    end else begin
      if (rsp_live) begin
        state_next = IDLE;
        owner_next = OWN_NONE;
      end
      if (m_req) begin
        lock_valid_next = 1'b1;
        lock_sel_next   = sel;
      end
    end

    if (!d_req || (accept && sel_d)) begin
      cnt_next = '0;
    end else if (accept && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_NONE;
      lock_valid_reg <= 1'b0;
      lock_sel_reg   <= OWN_NONE;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      lock_valid_reg <= lock_valid_next;
      lock_sel_reg   <= lock_sel_next;
      cnt_reg        <= cnt_next;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grants checked per cycle, responses checked
// against a queue of expected (owner, data) pushed at each grant.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p_req, p_wen, p_gnt, p_rvalid;
  logic [63:0] p_addr, p_wdata, p_rdata;
  logic [7:0]  p_byte_en;
  logic        d_req, d_wen, d_gnt, d_rvalid;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_byte_en;
  logic        m_req, m_wen, m_gnt, m_rvalid, unexpected_rsp;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_byte_en;

  typedef struct {
    logic        is_d;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  dmem_arbiter #(
    .STARVE_LIMIT(4),
    .CNT_W       (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .p_req         (p_req),
    .p_addr        (p_addr),
    .p_wdata       (p_wdata),
    .p_byte_en     (p_byte_en),
    .p_wen         (p_wen),
    .p_gnt         (p_gnt),
    .p_rvalid      (p_rvalid),
    .p_rdata       (p_rdata),
    .d_req         (d_req),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_byte_en     (d_byte_en),
    .d_wen         (d_wen),
    .d_gnt         (d_gnt),
    .d_rvalid      (d_rvalid),
    .d_rdata       (d_rdata),
    .m_req         (m_req),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_byte_en     (m_byte_en),
    .m_wen         (m_wen),
    .m_gnt         (m_gnt),
    .m_rvalid      (m_rvalid),
    .m_rdata       (m_rdata),
    .unexpected_rsp(unexpected_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("%s check did not hold", tag);
    end
  endtask

  task automatic chk_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s check did not hold", tag);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic [63:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
    $display("[TB] grant %s, expect response data %h", is_d ? "D" : "P", data);
  endtask

  task automatic expect_rsp(input string tag);
    exp_t e;
    tests++;
    assert (exp_q.size() != 0) else begin
      fails++;
      $display("FAIL %s_queue observed=empty expected=pending", tag);
      $error("%s scoreboard empty", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk_bit({tag, "_p_rvalid"}, p_rvalid, !e.is_d);
      chk_bit({tag, "_d_rvalid"}, d_rvalid, e.is_d);
      chk_word({tag, "_rdata"}, e.is_d ? d_rdata : p_rdata, e.data);
      chk_bit({tag, "_unexp"}, unexpected_rsp, 1'b0);
      $display("[TB] response %s data %h", e.is_d ? "D" : "P", e.data);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_bit({tag, "_p_gnt"}, p_gnt, 1'b0);
    chk_bit({tag, "_d_gnt"}, d_gnt, 1'b0);
    chk_bit({tag, "_p_rvalid"}, p_rvalid, 1'b0);
    chk_bit({tag, "_d_rvalid"}, d_rvalid, 1'b0);
    chk_bit({tag, "_m_req"}, m_req, 1'b0);
    chk_bit({tag, "_m_wen"}, m_wen, 1'b0);
    chk_bit({tag, "_unexp"}, unexpected_rsp, 1'b0);
  endtask

  initial begin
    logic [9:0] order;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    p_req = 1'b1; p_addr = 64'h1000; p_wdata = '0; p_byte_en = 8'hFF; p_wen = 1'b1;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_byte_en = '0; d_wen = 1'b0;
    m_gnt = 1'b1; m_rvalid = 1'b0; m_rdata = '0;

    // Reset state, with requests pending on the inputs
    repeat (2) tick();
    sample();
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    p_req = 1'b0; p_wen = 1'b0;

    // 1: P read
    p_req = 1'b1; p_addr = 64'h1000; m_gnt = 1'b1;
    sample();
    chk_bit("t1_m_req", m_req, 1'b1);
    chk_word("t1_m_addr", m_addr, 64'h1000);
    chk_bit("t1_m_wen", m_wen, 1'b0);
    chk_bit("t1_p_gnt", p_gnt, 1'b1);
    chk_bit("t1_d_gnt", d_gnt, 1'b0);
    push_exp(1'b0, 64'hDEADBEEF_CAFEF00D);
    tick();
    p_req = 1'b0; m_gnt = 1'b0;
    sample();
    chk_bit("t1_p_gnt_pulse", p_gnt, 1'b0);
    chk_bit("t1_no_rvalid", p_rvalid, 1'b0);
    tick();
    m_rvalid = 1'b1; m_rdata = 64'hDEADBEEF_CAFEF00D;
    sample();
    expect_rsp("t1");
    tick();
    // spurious response while idle
    m_rdata = 64'h1234;
    sample();
    chk_bit("t1_spur_unexp", unexpected_rsp, 1'b1);
    chk_bit("t1_spur_p_rvalid", p_rvalid, 1'b0);
    chk_bit("t1_spur_d_rvalid", d_rvalid, 1'b0);
    tick();
    m_rvalid = 1'b0;

    // 2: both requesting, back-to-back grants, starvation guard
    order = 10'b10000_10000;
    p_req = 1'b1; p_addr = 64'h100; d_req = 1'b1; d_addr = 64'h200; m_gnt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      m_rvalid = (k > 0);
      m_rdata  = 64'hA000 + 64'(k) - 64'd1;
      sample();
      if (k > 0) expect_rsp("t2");
      chk_bit("t2_p_gnt", p_gnt, !order[k]);
      chk_bit("t2_d_gnt", d_gnt, order[k]);
      chk_word("t2_m_addr", m_addr, order[k] ? 64'h200 : 64'h100);
      push_exp(order[k], 64'hA000 + 64'(k));
      tick();
    end
    p_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hA009;
    sample();
    expect_rsp("t2_last");
    chk_bit("t2_m_req_idle", m_req, 1'b0);
    tick();
    m_rvalid = 1'b0;

    // 3: P stalled by m_gnt low, D arrives, P keeps the port
    m_gnt = 1'b0; p_req = 1'b1; p_addr = 64'h1000; p_wen = 1'b0;
    sample();
    chk_bit("t3_m_req", m_req, 1'b1);
    chk_word("t3_m_addr0", m_addr, 64'h1000);
    tick();
    d_req = 1'b1; d_addr = 64'h2000; d_wen = 1'b0;
    for (int c = 1; c < 3; c++) begin
      sample();
      chk_word("t3_m_addr_hold", m_addr, 64'h1000);
      chk_bit("t3_no_gnt", p_gnt | d_gnt, 1'b0);
      tick();
    end
    m_gnt = 1'b1;
    sample();
    chk_bit("t3_p_gnt", p_gnt, 1'b1);
    chk_bit("t3_d_gnt", d_gnt, 1'b0);
    push_exp(1'b0, 64'h3333);
    tick();

    // 4: zero-bubble response + new D grant in the same cycle
    p_req = 1'b0; m_rvalid = 1'b1; m_rdata = 64'h3333;
    sample();
    expect_rsp("t4");
    chk_bit("t4_d_gnt", d_gnt, 1'b1);
    chk_word("t4_m_addr", m_addr, 64'h2000);
    push_exp(1'b1, 64'h4444);
    tick();
    d_req = 1'b0; m_rdata = 64'h4444;
    sample();
    expect_rsp("t4_owner_d");
    chk_bit("t4_m_req", m_req, 1'b0);
    tick();
    m_rvalid = 1'b0;

    // 5: D write, held against a later P request until accepted
    m_gnt = 1'b0;
    d_req = 1'b1; d_addr = 64'h2008; d_byte_en = 8'h0F; d_wdata = 64'h11223344; d_wen = 1'b1;
    sample();
    chk_bit("t5_m_wen", m_wen, 1'b1);
    chk_word("t5_m_byte_en", {56'h0, m_byte_en}, 64'h0F);
    chk_word("t5_m_addr", m_addr, 64'h2008);
    chk_word("t5_m_wdata", m_wdata, 64'h11223344);
    tick();
    p_req = 1'b1; p_addr = 64'h3000;
    sample();
    chk_word("t5_m_addr_lock", m_addr, 64'h2008);
    chk_bit("t5_m_wen_lock", m_wen, 1'b1);
    tick();
    m_gnt = 1'b1;
    sample();
    chk_bit("t5_d_gnt", d_gnt, 1'b1);
    chk_bit("t5_p_gnt", p_gnt, 1'b0);
    push_exp(1'b1, 64'h5555);
    tick();
    d_req = 1'b0; d_wen = 1'b0; p_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 64'h5555;
    sample();
    expect_rsp("t5");
    tick();
    m_rvalid = 1'b0;

    // 6: reset during WAIT_RSP, late response afterwards
    p_req = 1'b1; p_addr = 64'h4000; m_gnt = 1'b1;
    sample();
    chk_bit("t6_p_gnt", p_gnt, 1'b1);
    tick();
    p_req = 1'b0; m_gnt = 1'b0;
    sample();
    chk_bit("t6_wait_m_req", m_req, 1'b0);
    rst_n = 1'b0; p_req = 1'b1; p_wen = 1'b1; d_req = 1'b1; m_gnt = 1'b1; m_rvalid = 1'b1;
    #1;
    chk_all_zero("t6_in_reset");
    tick();
    rst_n = 1'b1; p_req = 1'b0; p_wen = 1'b0; d_req = 1'b0; m_gnt = 1'b0;
    sample();
    chk_bit("t6_unexp", unexpected_rsp, 1'b1);
    chk_bit("t6_p_rvalid", p_rvalid, 1'b0);
    chk_bit("t6_d_rvalid", d_rvalid, 1'b0);
    tick();
    m_rvalid = 1'b0;
    sample();
    chk_bit("t6_unexp_once", unexpected_rsp, 1'b0);

    chk_word("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
